nim_turn_controller: RTL
========================

NIM_TURN_CONTROLLER -- requirements
Module: nim_turn_controller

Interface
REQ-001 SHALL have parameter INIT_H0, default 1, initial stone count of row 0.
REQ-002 SHALL have parameter INIT_H1, default 3, initial stone count of row 1.
REQ-003 SHALL have parameter INIT_H2, default 5, initial stone count of row 2.
REQ-004 SHALL have parameter INIT_H3, default 7, initial stone count of row 3.
REQ-005 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port row_sel  input  4  debounced level per row button; bit k selects row k.
REQ-008 SHALL have port ch_player  input  1  debounced level, end-of-turn request.
REQ-009 SHALL have port new_game  input  1  debounced level, restart request.
REQ-010 SHALL have port heap0..heap3  output  3 each  current stone count per row, for the display stage.
REQ-011 SHALL have port cur_player  output  1  player to move (0 = left, 1 = right).
REQ-012 SHALL have port locked_row  output  4  one-hot row locked this turn; 0 when unlocked.
REQ-013 SHALL have port game_over  output  1  high while in OVER state.
REQ-014 SHALL have port inc_left, inc_right  output  1 each  one-cycle win pulses to the scoreboards.

Function
REQ-015 SHALL convert every level input to a one-cycle rising-edge event internally; held levels SHALL NOT repeat.
REQ-016 SHALL implement states OPEN (turn started, no removal yet), LOCKED (at least one removal made this turn) and OVER.
REQ-017 In OPEN, a single row-k event with heap k > 0 SHALL decrement heap k by 1, set locked_row to bit k and go to LOCKED, all on the next edge.
REQ-018 In LOCKED, a row event for the locked row with heap > 0 SHALL decrement it; events for any other row SHALL be ignored.
REQ-019 A row event for an empty heap SHALL be ignored in every state; heaps SHALL never wrap below 0.
REQ-020 Two or more row events in the same cycle SHALL all be ignored.
REQ-021 A ch_player event in LOCKED SHALL toggle cur_player, clear locked_row and go to OPEN; in OPEN it SHALL be ignored (no pass allowed).
REQ-022 A row event and a ch_player event in the same cycle SHALL process the removal and ignore ch_player.
REQ-023 The removal that makes all four heaps 0 SHALL enter OVER on the next edge and pulse inc_left (cur_player = 0) or inc_right (cur_player = 1) for exactly one cycle: taking the last stone wins.
REQ-024 In OVER, row and ch_player events SHALL be ignored; cur_player SHALL hold the winner.
REQ-025 A new_game event in any state SHALL restore heaps to INIT_H0..3, set cur_player = 0, clear locked_row and enter OPEN; it SHALL take priority over all same-cycle events.
REQ-026 All outputs SHALL be registered; the latency from an input rising edge to the output change SHALL be 2 cycles (edge register plus state register).

Reset
REQ-027 While reset = 0, state SHALL be OPEN, heaps SHALL be INIT_H0..3, cur_player = 0, locked_row = 0, game_over = 0 and inc_left = inc_right = 0.
REQ-028 Edge-detect history registers SHALL reset to 1, so buttons held through reset release SHALL NOT generate events.
REQ-029 Reset asserted mid-turn or in OVER SHALL abort immediately, with no win pulse emitted.

Structure
REQ-030 Package nim_pkg SHALL hold the state enum (OPEN, LOCKED, OVER), HEAP_W = 3, NUM_ROWS = 4 and the default initial heap constants.
REQ-031 Rising-edge detection SHALL be one sub-module, edge_pulse, instantiated once per input (six instances).
REQ-032 Width check: every INIT_Hk SHALL fit HEAP_W bits (max 7).

Verification
REQ-033 After reset, pulse row_sel[3] three times then ch_player -> heap3 = 4, cur_player = 1, locked_row = 0.
REQ-034 In LOCKED on row 1, pulse row_sel[2] -> heap2 unchanged at 5; then pulse row_sel[1] -> heap1 decrements.
REQ-035 In OPEN, pulse ch_player alone -> no change; pulse row_sel[0] and row_sel[1] in the same cycle -> no change.
REQ-036 Empty all heaps with cur_player = 1 taking the last stone -> game_over = 1, a single inc_right pulse, and further row/ch_player events ignored.
REQ-037 Pulse new_game in the same cycle as row_sel[3] mid-game -> heaps = 1/3/5/7, cur_player = 0, state OPEN.
REQ-038 Hold row_sel[2] high across reset release, then assert reset = 0 mid-turn -> no event on release, and all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/nim_pkg.sv
// Shared types and constants for the Nim turn controller.
package nim_pkg;

   localparam int HEAP_W    = 3;
   localparam int NUM_ROWS  = 4;
   localparam int ROW_IDX_W = $clog2(NUM_ROWS);
   localparam int MAX_HEAP  = (1 << HEAP_W) - 1;

   localparam int DEF_H0 = 1;
   localparam int DEF_H1 = 3;
   localparam int DEF_H2 = 5;
   localparam int DEF_H3 = 7;

   typedef enum logic [1:0] {
      ST_OPEN   = 2'd0,
      ST_LOCKED = 2'd1,
      ST_OVER   = 2'd2
   } nim_state_e;

   typedef logic [NUM_ROWS-1:0][HEAP_W-1:0] heap_t;

   function automatic logic heaps_empty(input heap_t h);
      return (h == '0);
   endfunction

endpackage

// File: rtl/edge_pulse.sv
// Registered rising-edge detector; history starts high so a level held
// through reset release does not count as a new press.
module edge_pulse (
   input  logic clk,
   input  logic reset,
   input  logic level,
   output logic pulse
);

   logic level_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         level_q <= 1'b1;
         pulse   <= 1'b0;
      end else begin
         level_q <= level;
         pulse   <= level & ~level_q;
      end
   end

endmodule

// File: rtl/nim_turn_controller.sv
// Turn sequencing for four-row Nim: one row per turn, last stone wins.
//
// state     | meaning
// ----------+---------------------------------------------------
// ST_OPEN   | turn started, no stone removed yet
// ST_LOCKED | at least one stone removed; only locked row usable
// ST_OVER   | all heaps empty, cur_player holds the winner
module nim_turn_controller
   import nim_pkg::*;
#(
   parameter int INIT_H0 = DEF_H0,
   parameter int INIT_H1 = DEF_H1,
   parameter int INIT_H2 = DEF_H2,
   parameter int INIT_H3 = DEF_H3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_ROWS-1:0] row_sel,
   input  logic                ch_player,
   input  logic                new_game,
   output logic [HEAP_W-1:0]   heap0,
   output logic [HEAP_W-1:0]   heap1,
   output logic [HEAP_W-1:0]   heap2,
   output logic [HEAP_W-1:0]   heap3,
   output logic                cur_player,
   output logic [NUM_ROWS-1:0] locked_row,
   output logic                game_over,
   output logic                inc_left,
   output logic                inc_right
);

   if (INIT_H0 < 0 || INIT_H0 > MAX_HEAP || INIT_H1 < 0 || INIT_H1 > MAX_HEAP ||
       INIT_H2 < 0 || INIT_H2 > MAX_HEAP || INIT_H3 < 0 || INIT_H3 > MAX_HEAP) begin : g_init_range
      $error("nim_turn_controller: INIT_Hk must lie in 0..%0d", MAX_HEAP);
   end

   localparam heap_t INIT_HEAPS = {HEAP_W'(INIT_H3), HEAP_W'(INIT_H2),
                                   HEAP_W'(INIT_H1), HEAP_W'(INIT_H0)};

   logic [NUM_ROWS-1:0] row_evt;
   logic                ch_evt;
   logic                ng_evt;

   for (genvar i = 0; i < NUM_ROWS; i++) begin : g_row_edge
      edge_pulse u_row_edge (
         .clk   (clk),
         .reset (reset),
         .level (row_sel[i]),
         .pulse (row_evt[i])
      );
   end

   edge_pulse u_ch_edge (
      .clk   (clk),
      .reset (reset),
      .level (ch_player),
      .pulse (ch_evt)
   );

   edge_pulse u_ng_edge (
      .clk   (clk),
      .reset (reset),
      .level (new_game),
      .pulse (ng_evt)
   );

   nim_state_e          state_q, state_nxt;
   heap_t               heap_q, heap_nxt;
   logic                player_q, player_nxt;
   logic [NUM_ROWS-1:0] lock_q, lock_nxt;
   logic                over_q, over_nxt;
   logic                win_l_q, win_l_nxt;
   logic                win_r_q, win_r_nxt;

   logic [ROW_IDX_W-1:0] row_idx;
   logic                 can_take;
   heap_t                take_heaps;

   // Simultaneous presses are rejected outright, so only a one-hot event
   // can ever name a row.
   always_comb begin
      row_idx = '0;
      for (int i = 0; i < NUM_ROWS; i++) begin
         if (row_evt[i]) row_idx = ROW_IDX_W'(i);
      end
      can_take            = $onehot(row_evt) && (heap_q[row_idx] != '0);
      take_heaps          = heap_q;
      take_heaps[row_idx] = heap_q[row_idx] - 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_OPEN;
         heap_q   <= INIT_HEAPS;
         player_q <= 1'b0;
         lock_q   <= '0;
         over_q   <= 1'b0;
         win_l_q  <= 1'b0;
         win_r_q  <= 1'b0;
      end else begin
         state_q  <= state_nxt;
         heap_q   <= heap_nxt;
         player_q <= player_nxt;
         lock_q   <= lock_nxt;
         over_q   <= over_nxt;
         win_l_q  <= win_l_nxt;
         win_r_q  <= win_r_nxt;
      end
   end

   always_comb begin
      state_nxt  = state_q;
      heap_nxt   = heap_q;
      player_nxt = player_q;
      lock_nxt   = lock_q;
      if (ng_evt) begin
         state_nxt  = ST_OPEN;
         heap_nxt   = INIT_HEAPS;
         player_nxt = 1'b0;
         lock_nxt   = '0;
      end else begin
         unique case (state_q)
            ST_OPEN: begin
               if (can_take) begin
                  heap_nxt = take_heaps;
                  if (heaps_empty(take_heaps)) begin
                     state_nxt = ST_OVER;
                     lock_nxt  = '0;
                  end else begin
                     state_nxt = ST_LOCKED;
                     lock_nxt  = row_evt;
                  end
               end
            end
            ST_LOCKED: begin
               // Any row press in the cycle suppresses the end-of-turn request.
               if (can_take && (row_evt == lock_q)) begin
                  heap_nxt = take_heaps;
                  if (heaps_empty(take_heaps)) begin
                     state_nxt = ST_OVER;
                     lock_nxt  = '0;
                  end
               end else if (ch_evt && (row_evt == '0)) begin
                  state_nxt  = ST_OPEN;
                  player_nxt = ~player_q;
                  lock_nxt   = '0;
               end
            end
            ST_OVER: begin
               state_nxt = ST_OVER;
            end
            default: begin
               state_nxt = ST_OPEN;
               lock_nxt  = '0;
            end
         endcase
      end
   end

   always_comb begin
      over_nxt  = (state_nxt == ST_OVER);
      win_l_nxt = (state_q != ST_OVER) && (state_nxt == ST_OVER) && !player_q;
      win_r_nxt = (state_q != ST_OVER) && (state_nxt == ST_OVER) &&  player_q;
   end

   assign heap0      = heap_q[0];
   assign heap1      = heap_q[1];
   assign heap2      = heap_q[2];
   assign heap3      = heap_q[3];
   assign cur_player = player_q;
   assign locked_row = lock_q;
   assign game_over  = over_q;
   assign inc_left   = win_l_q;
   assign inc_right  = win_r_q;

endmodule
